// File: rtl/play_jtag_pkg.sv
// play_jtag_pkg: shared state encoding, symbol bit positions and word geometry helper.
package play_jtag_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT_REQ, S_HOLD, S_WRITE, S_DONE} state_e;
  localparam int TMS_BIT = 1;
  localparam int TDI_BIT = 0;
  function automatic int spw(input int word_w, input int sym_w);
    return word_w / sym_w;
  endfunction
endpackage

// File: rtl/play_jtag_vector_seq_jtag_req_sync.sv
// jtag_req_sync: STAGES-deep flop synchroniser for asynchronous driver-side signals.
module jtag_req_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  end
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/play_jtag_vector_seq.sv
// play_jtag_vector_seq: plays {TMS,TDI} symbols from vector RAM to the JTAG driver over a 4-phase handshake.
// Optional TDO capture back into RAM is enabled by defining PLAY_JTAG_TDO_CAPTURE_EN.
module play_jtag_vector_seq
  import play_jtag_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WORD_W      = 8,
  parameter int SYM_W       = 2,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CAP_BASE    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  vector_start,
  input  logic [CNT_W-1:0]  vector_end,
  input  logic [CNT_W-1:0]  vector_number_repeat,
  input  logic [CNT_W-1:0]  adc_start_delay,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wr_data,
  input  logic              get_next_data,
  input  logic              tdo,
  output logic [SYM_W-1:0]  vector_data,
  output logic              data_ready,
  output logic              wait_state,
  output logic              busy,
  output logic              done,
  output logic              adc_start,
  output logic              adc_sequence_one
);
  localparam int SPW = spw(WORD_W, SYM_W);
  localparam logic [CNT_W-1:0] SPW_C = CNT_W'(SPW);
  localparam logic [CNT_W-1:0] SYM_C = CNT_W'(SYM_W);
  state_e state_q, state_d, nxt;
  logic [CNT_W-1:0] idx_q, idx_d, pass_q, pass_d, vs_q, vs_d, ve_q, ve_d, passes_q, passes_d, delay_q, delay_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [SYM_W-1:0] vector_data_q, vector_data_d, sym;
  logic data_ready_q, data_ready_d, adc_start_q, adc_start_d, fcnt_q, fcnt_d;
  logic req_s, at_end, finish, crosses;
  jtag_req_sync #(.STAGES(SYNC_STAGES)) u_req_sync (.clk(clk), .rst_n(rst_n), .d(get_next_data), .q(req_s));
`ifdef PLAY_JTAG_TDO_CAPTURE_EN
  localparam int BIT_W = $clog2(WORD_W);
  logic tdo_s;
  logic [WORD_W-1:0] cap_sr_q, cap_sr_d;
  logic [BIT_W-1:0] cap_cnt_q, cap_cnt_d;
  logic [ADDR_W-1:0] cap_idx_q, cap_idx_d;
  state_e ret_q, ret_d;
  jtag_req_sync #(.STAGES(SYNC_STAGES)) u_tdo_sync (.clk(clk), .rst_n(rst_n), .d(tdo), .q(tdo_s));
  assign mem_we      = state_q == S_WRITE;
  assign mem_wr_data = cap_sr_q;
  assign mem_addr    = mem_we ? ADDR_W'(CAP_BASE) + cap_idx_q : ADDR_W'(idx_q / SPW_C);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_sr_q  <= '0;
      cap_cnt_q <= '0;
      cap_idx_q <= '0;
      ret_q     <= S_IDLE;
    end else begin
      cap_sr_q  <= cap_sr_d;
      cap_cnt_q <= cap_cnt_d;
      cap_idx_q <= cap_idx_d;
      ret_q     <= ret_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^{tdo, 32'(CAP_BASE)};
  assign mem_we      = 1'b0;
  assign mem_wr_data = '0;
  assign mem_addr    = ADDR_W'(idx_q / SPW_C);
`endif
  assign sym     = SYM_W'(word_q >> (SYM_C * (idx_q % SPW_C)));
  assign at_end  = idx_q == ve_q;
  assign finish  = at_end && (pass_q + CNT_W'(1) == passes_q);
  assign crosses = ((idx_q + CNT_W'(1)) % SPW_C) == '0;
  assign nxt     = finish ? S_DONE : (at_end || crosses) ? S_FETCH : S_WAIT_REQ;
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pass_d        = pass_q;
    vs_d          = vs_q;
    ve_d          = ve_q;
    passes_d      = passes_q;
    delay_d       = delay_q;
    word_d        = word_q;
    vector_data_d = vector_data_q;
    data_ready_d  = data_ready_q;
    adc_start_d   = 1'b0;
    fcnt_d        = 1'b0;
`ifdef PLAY_JTAG_TDO_CAPTURE_EN
    cap_sr_d      = cap_sr_q;
    cap_cnt_d     = cap_cnt_q;
    cap_idx_d     = cap_idx_q;
    ret_d         = ret_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        vs_d     = vector_start;
        ve_d     = vector_end;
        passes_d = vector_number_repeat == '0 ? CNT_W'(1) : vector_number_repeat;
        delay_d  = adc_start_delay;
        idx_d    = vector_start;
        pass_d   = '0;
        state_d  = vector_end < vector_start ? S_DONE : S_FETCH;
`ifdef PLAY_JTAG_TDO_CAPTURE_EN
        cap_sr_d  = '0;
        cap_cnt_d = '0;
        cap_idx_d = '0;
`endif
      end
      // first cycle lets the RAM register the address, second latches its data
      S_FETCH: begin
        fcnt_d = ~fcnt_q;
        if (fcnt_q) begin
          word_d  = mem_rd_data;
          state_d = S_WAIT_REQ;
        end
      end
      S_WAIT_REQ: if (req_s && !data_ready_q) begin
        vector_data_d = sym;
        data_ready_d  = 1'b1;
        adc_start_d   = (idx_q - vs_q) == delay_q;
        state_d       = S_HOLD;
      end
      S_HOLD: if (!req_s) begin
        data_ready_d = 1'b0;
        state_d      = nxt;
        if (at_end) begin
          idx_d = vs_q;
          if (!finish) pass_d = pass_q + CNT_W'(1);
        end else idx_d = idx_q + CNT_W'(1);
`ifdef PLAY_JTAG_TDO_CAPTURE_EN
        cap_sr_d[cap_cnt_q] = tdo_s;
        cap_cnt_d           = cap_cnt_q + BIT_W'(1);
        if (finish || cap_cnt_q == BIT_W'(WORD_W - 1)) begin
          state_d = S_WRITE;
          ret_d   = nxt;
        end
`endif
      end
`ifdef PLAY_JTAG_TDO_CAPTURE_EN
      S_WRITE: begin
        cap_idx_d = cap_idx_q + ADDR_W'(1);
        cap_sr_d  = '0;
        cap_cnt_d = '0;
        state_d   = ret_q;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d      = S_IDLE;
      data_ready_d = 1'b0;
      adc_start_d  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      pass_q        <= '0;
      vs_q          <= '0;
      ve_q          <= '0;
      passes_q      <= '0;
      delay_q       <= '0;
      word_q        <= '0;
      vector_data_q <= '0;
      data_ready_q  <= 1'b0;
      adc_start_q   <= 1'b0;
      fcnt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pass_q        <= pass_d;
      vs_q          <= vs_d;
      ve_q          <= ve_d;
      passes_q      <= passes_d;
      delay_q       <= delay_d;
      word_q        <= word_d;
      vector_data_q <= vector_data_d;
      data_ready_q  <= data_ready_d;
      adc_start_q   <= adc_start_d;
      fcnt_q        <= fcnt_d;
    end
  end
  assign vector_data      = vector_data_q;
  assign data_ready       = data_ready_q;
  assign adc_start        = adc_start_q;
  assign wait_state       = state_q == S_WAIT_REQ;
  assign done             = state_q == S_DONE;
  assign busy             = !(state_q == S_IDLE || state_q == S_DONE);
  assign adc_sequence_one = busy && pass_q == '0;
endmodule

// File: tb/tb_play_jtag_vector_seq.sv
// tb_play_jtag_vector_seq: randomized handshake player checked against a symbol-list reference model.
module tb_play_jtag_vector_seq;
  localparam int CAP = 2048;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, get_next_data = 0, tdo = 0;
  logic [15:0] vector_start = 0, vector_end = 0, vector_number_repeat = 0, adc_start_delay = 0;
  logic [11:0] mem_addr;
  logic [7:0] mem_rd_data, mem_wr_data;
  logic mem_we, data_ready, wait_state, busy, done, adc_start, adc_sequence_one;
  logic [1:0] vector_data;
  logic [7:0] ram [0:4095];
  logic [19:0] wr_log[$];
  int checks = 0, errors = 0, adc_cnt = 0, dr_rise = 0, we_cnt = 0;
  logic dr_prev = 0;
  always #5 clk = ~clk;
  play_jtag_vector_seq #(.CAP_BASE(CAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vector_start(vector_start), .vector_end(vector_end),
    .vector_number_repeat(vector_number_repeat), .adc_start_delay(adc_start_delay),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_we(mem_we), .mem_wr_data(mem_wr_data),
    .get_next_data(get_next_data), .tdo(tdo), .vector_data(vector_data), .data_ready(data_ready),
    .wait_state(wait_state), .busy(busy), .done(done), .adc_start(adc_start),
    .adc_sequence_one(adc_sequence_one)
  );
  always @(posedge clk) begin
    mem_rd_data <= ram[mem_addr];
    if (mem_we) begin
      ram[mem_addr] <= mem_wr_data;
      wr_log.push_back({mem_addr, mem_wr_data});
    end
  end
  always @(negedge clk) begin
    if (adc_start) adc_cnt++;
    if (data_ready && !dr_prev) dr_rise++;
    if (mem_we) we_cnt++;
    dr_prev = data_ready;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] sym_of(input int i);
    logic [7:0] w;
    w = ram[i / 4];
    return w[2 * (i % 4) +: 2];
  endfunction
  task automatic pulse_start(input int vs, input int ve, input int rep, input int dly);
    @(negedge clk);
    vector_start = 16'(vs);
    vector_end = 16'(ve);
    vector_number_repeat = 16'(rep);
    adc_start_delay = 16'(dly);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_cond_wait_state();
    int n = 0;
    while (!wait_state && n < 100) begin @(negedge clk); n++; end
    check("wait_state", 32'(wait_state), 1);
  endtask
  task automatic run_play(input int vs, input int ve, input int rep, input int dly);
    int passes, n, a0, cap_n;
    logic [7:0] cap_w;
    logic [19:0] exp_wr[$];
    bit tb;
    passes = rep == 0 ? 1 : rep;
    a0 = adc_cnt;
    wr_log.delete();
    cap_w = 0;
    cap_n = 0;
    pulse_start(vs, ve, rep, dly);
    for (int p = 0; p < passes; p++)
      for (int i = vs; i <= ve; i++) begin
        wait_cond_wait_state();
        tb = 1'($urandom_range(0, 1));
        tdo = tb;
        get_next_data = 1;
        n = 0;
        while (!data_ready && n < 20) begin @(negedge clk); n++; end
        check("latency", 32'(n), 3);
        check("symbol", 32'(vector_data), 32'(sym_of(i)));
        check("adc_start", 32'(adc_start), 32'((i - vs) == dly));
        check("seq_one", 32'(adc_sequence_one), 32'(p == 0));
        check("busy_play", 32'(busy), 1);
        get_next_data = 0;
        n = 0;
        while (data_ready && n < 20) begin @(negedge clk); n++; end
        check("release", 32'(data_ready), 0);
        cap_w[cap_n] = tb;
        cap_n++;
        if (cap_n == 8) begin
          exp_wr.push_back({12'(CAP + exp_wr.size()), cap_w});
          cap_w = 0;
          cap_n = 0;
        end
      end
    if (cap_n != 0) exp_wr.push_back({12'(CAP + exp_wr.size()), cap_w});
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    check("done", 32'(done), 1);
    check("busy_done", 32'(busy), 0);
    check("adc_count", 32'(adc_cnt - a0), 32'(dly <= ve - vs ? passes : 0));
`ifdef PLAY_JTAG_TDO_CAPTURE_EN
    check("cap_writes", 32'(wr_log.size()), 32'(exp_wr.size()));
    for (int k = 0; k < exp_wr.size() && k < wr_log.size(); k++) check("cap_word", 32'(wr_log[k]), 32'(exp_wr[k]));
`else
    check("no_write", 32'(we_cnt), 0);
`endif
  endtask
  task automatic check_idle_outputs(input string tag);
    check(tag, {mem_addr, mem_wr_data, mem_we, vector_data, data_ready, wait_state, busy, done, adc_start, adc_sequence_one}, 0);
  endtask
  initial begin
    int d0, n;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    ram[0] = 8'hE4;
    ram[1] = 8'h1B;
    #1 check_idle_outputs("reset_state");
    repeat (3) @(negedge clk);
    rst_n = 1;
    run_play(0, 7, 1, 20);
    for (int i = 0; i < 8; i++) check("e4_1b_symbol", 32'(sym_of(i)), 32'((i < 4) ? i : 7 - i));
    run_play(5, 6, 3, 0);
    run_play(4, 9, 2, 2);
    run_play(10, 14, 0, 4);
    d0 = dr_rise;
    pulse_start(4, 3, 1, 0);
    @(negedge clk);
    check("empty_done", 32'(done), 1);
    check("empty_busy", 32'(busy), 0);
    get_next_data = 1;
    repeat (8) @(negedge clk);
    get_next_data = 0;
    repeat (4) @(negedge clk);
    check("empty_no_ready", 32'(dr_rise - d0), 0);
    pulse_start(8, 15, 1, 3);
    wait_cond_wait_state();
    get_next_data = 1;
    n = 0;
    while (!data_ready && n < 20) begin @(negedge clk); n++; end
    check("abort_pre_ready", 32'(data_ready), 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("abort_ready", 32'(data_ready), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    get_next_data = 0;
    repeat (5) @(negedge clk);
    run_play(8, 15, 1, 3);
    for (int t = 0; t < 8; t++) begin
      int vs, len;
      vs = $urandom_range(0, 60);
      len = $urandom_range(0, 9);
      run_play(vs, vs + len, $urandom_range(0, 3), $urandom_range(0, 11));
    end
    pulse_start(20, 40, 2, 1);
    wait_cond_wait_state();
    get_next_data = 1;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1 check_idle_outputs("reset_mid_play");
    get_next_data = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    run_play(2, 5, 1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
